// File: rtl/cascade_load_sequencer_pkg.sv
// Shared state encodings, header field positions and the header decoder
// for the host load stream sequencer.
package pkg_load_seq;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam int HDR_LAST_BIT = 63;
  localparam int HDR_ID_LSB   = 32;

  // Fields are held at their widest legal size; the caller slices them down.
  typedef struct packed {
    logic        last;
    logic [30:0] id;
    logic [31:0] count;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [63:0] word,
                                      input int cnt_width,
                                      input int id_width);
    hdr_t        h;
    logic [31:0] cmask;
    logic [30:0] imask;
    cmask   = (cnt_width >= 32) ? '1 : ((32'd1 << cnt_width) - 32'd1);
    imask   = (31'd1 << id_width) - 31'd1;
    h.count = word[31:0] & cmask;
    h.id    = word[HDR_ID_LSB +: 31] & imask;
    h.last  = word[HDR_LAST_BIT];
    return h;
  endfunction

endpackage

// File: rtl/cascade_load_sequencer_mux.sv
// Steers host valid to the selected client and returns that client's accept.
// Purely combinational; idle (all zero) unless enabled.
module load_seq_mux #(
  parameter int NUM_CLIENTS = 4,
  parameter int SEL_WIDTH   = 4
) (
  input  logic                   en_i,
  input  logic [SEL_WIDTH-1:0]   sel_i,
  input  logic                   data_ready_i,
  input  logic [NUM_CLIENTS-1:0] cl_data_wanted_i,
  output logic [NUM_CLIENTS-1:0] cl_data_ready_o,
  output logic                   sel_wanted_o
);

  always_comb begin
    cl_data_ready_o = '0;
    sel_wanted_o    = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (en_i && (sel_i == SEL_WIDTH'(i))) begin
        cl_data_ready_o[i] = data_ready_i;
        sel_wanted_o       = cl_data_wanted_i[i];
      end
    end
  end

endmodule

// File: rtl/cascade_load_sequencer.sv
// Splits the host load stream into header-addressed segments and routes each
// payload word straight through to the named client, tracking per-client loaded.
module cascade_load_sequencer
  import pkg_load_seq::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CNT_WIDTH   = 24,
  parameter int ID_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [63:0]            data,
  input  logic                   data_ready,
  output logic                   data_wanted,
  output logic [63:0]            cl_data,
  output logic [NUM_CLIENTS-1:0] cl_data_ready,
  input  logic [NUM_CLIENTS-1:0] cl_data_wanted,
  output logic [NUM_CLIENTS-1:0] loaded,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  logic [2:0]             state_q,  state_d;
  logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
  logic [ID_WIDTH-1:0]    sel_q,    sel_d;
  logic                   last_q,   last_d;
  logic [NUM_CLIENTS-1:0] loaded_q, loaded_d;

  hdr_t                   hdr;
  logic [CNT_WIDTH-1:0]   hdr_cnt;
  logic [ID_WIDTH-1:0]    hdr_id;
  logic                   hdr_id_ok;
  logic                   hdr_unused;
  logic [NUM_CLIENTS-1:0] hdr_mask;
  logic [NUM_CLIENTS-1:0] sel_mask;
  logic                   sel_wanted;
  logic                   xfer;

  assign hdr        = decode_hdr(data, CNT_WIDTH, ID_WIDTH);
  assign hdr_cnt    = hdr.count[CNT_WIDTH-1:0];
  assign hdr_id     = hdr.id[ID_WIDTH-1:0];
  assign hdr_id_ok  = ({1'b0, hdr.id} < 32'(NUM_CLIENTS));
  assign hdr_unused = ^hdr.count;

  always_comb begin
    hdr_mask = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      hdr_mask[i] = (hdr_id == ID_WIDTH'(i));
      sel_mask[i] = (sel_q == ID_WIDTH'(i));
    end
  end

  load_seq_mux #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .SEL_WIDTH   (ID_WIDTH)
  ) u_mux (
    .en_i             (state_q == ST_STREAM),
    .sel_i            (sel_q),
    .data_ready_i     (data_ready),
    .cl_data_wanted_i (cl_data_wanted),
    .cl_data_ready_o  (cl_data_ready),
    .sel_wanted_o     (sel_wanted)
  );

  assign cl_data     = data;
  assign data_wanted = (state_q == ST_HDR) || ((state_q == ST_STREAM) && sel_wanted);
  assign xfer        = data_ready && data_wanted;
  assign loaded      = loaded_q;
  assign busy        = (state_q == ST_HDR) || (state_q == ST_STREAM);
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    loaded_d = loaded_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR;
          loaded_d = '0;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          cnt_d  = hdr_cnt;
          sel_d  = hdr_id;
          last_d = hdr.last;
          if (!hdr_id_ok) begin
            state_d = ST_ERR;
          end else if (hdr_cnt == '0) begin
            loaded_d = loaded_q | hdr_mask;
            state_d  = hdr.last ? ST_DONE : ST_HDR;
          end else begin
            // A repeated id reloads that client, so its flag drops until refilled.
            loaded_d = loaded_q & ~hdr_mask;
            state_d  = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) begin
            loaded_d = loaded_q | sel_mask;
            state_d  = last_q ? ST_DONE : ST_HDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      last_q   <= 1'b0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: tb/tb_cascade_load_sequencer.sv
// Directed stimulus with a payload scoreboard: the host driver queues each
// expected client delivery and an independent monitor checks actual deliveries.
module tb_cascade_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] data;
  logic        data_ready;
  logic        data_wanted;
  logic [63:0] cl_data;
  logic [3:0]  cl_data_ready;
  logic [3:0]  cl_data_wanted;
  logic [3:0]  loaded;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [63:0] d;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cascade_load_sequencer #(
    .NUM_CLIENTS (4),
    .CNT_WIDTH   (24),
    .ID_WIDTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data           (data),
    .data_ready     (data_ready),
    .data_wanted    (data_wanted),
    .cl_data        (cl_data),
    .cl_data_ready  (cl_data_ready),
    .cl_data_wanted (cl_data_wanted),
    .loaded         (loaded),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // {data_wanted, cl_data_ready, loaded, busy, done, err}
  function automatic logic [11:0] outs();
    return {data_wanted, cl_data_ready, loaded, busy, done, err};
  endfunction

  // Deliveries are sampled mid-low-phase, after all drivers have settled.
  always @(negedge clk) begin
    logic [3:0] dlv;
    exp_t       e;
    #3;
    dlv = cl_data_ready & cl_data_wanted;
    if (!reset && dlv != 4'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_delivery: got ready=%0h data=%0h expected none", cl_data_ready, cl_data);
      end else begin
        e = exp_q.pop_front();
        check("deliv_client", 64'(cl_data_ready), 64'(4'b0001) << e.id);
        check("deliv_data", cl_data, e.d);
        check("deliv_host_wanted", 64'(data_wanted), 64'd1);
      end
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic send(input logic [63:0] w);
    bit ok;
    ok = 1'b0;
    data       = w;
    data_ready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (data_wanted) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %0h not accepted, expected acceptance", w);
    end
  endtask

  task automatic hdr(input logic [63:0] w);
    @(negedge clk);
    send(w);
  endtask

  task automatic pay(input int id, input logic [63:0] w);
    @(negedge clk);
    exp_q.push_back('{id, w});
    send(w);
  endtask

  task automatic idle();
    @(negedge clk);
    data_ready = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    data           = '0;
    data_ready     = 1'b0;
    cl_data_wanted = 4'b1111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outputs", 64'(outs()), 64'h000);

    // Single segment: last, id2, count3
    pulse_start();
    check("t1_armed_wanted_busy", 64'({data_wanted, busy}), 64'b11);
    hdr(64'h8000_0002_0000_0003);
    pay(2, 64'h1111_0000_0000_0001);
    pay(2, 64'h1111_0000_0000_0002);
    pay(2, 64'h1111_0000_0000_0003);
    idle();
    check("t1_loaded", 64'(loaded), 64'h4);
    check("t1_busy_done_err", 64'({busy, done, err}), 64'b010);

    // Back-to-back segments with a two-cycle client-0 stall
    pulse_start();
    check("t2_loaded_cleared", 64'(loaded), 64'h0);
    hdr(64'h0000_0000_0000_0002);
    pay(0, 64'h2222_0000_0000_00A0);
    @(negedge clk);
    exp_q.push_back('{0, 64'h2222_0000_0000_00A1});
    data           = 64'h2222_0000_0000_00A1;
    data_ready     = 1'b1;
    cl_data_wanted = 4'b1110;
    #1;
    check("t2_stall1_wanted", 64'(data_wanted), 64'd0);
    check("t2_stall_valid_held", 64'(cl_data_ready), 64'h1);
    @(negedge clk);
    #1;
    check("t2_stall2_wanted", 64'(data_wanted), 64'd0);
    @(negedge clk);
    cl_data_wanted = 4'b1111;
    send(64'h2222_0000_0000_00A1);
    hdr(64'h8000_0003_0000_0001);
    pay(3, 64'h2222_0000_0000_00B0);
    idle();
    check("t2_loaded", 64'(loaded), 64'h9);
    check("t2_done", 64'(done), 64'd1);

    // Zero-count header for client 1, then last header for client 0
    pulse_start();
    hdr(64'h0000_0001_0000_0000);
    @(negedge clk);
    #1;
    check("t3_zero_count_loaded", 64'(loaded), 64'h2);
    send(64'h8000_0000_0000_0001);
    pay(0, 64'h3333_0000_0000_00C0);
    idle();
    check("t3_loaded", 64'(loaded), 64'h3);
    check("t3_done", 64'(done), 64'd1);

    // Out-of-range id
    pulse_start();
    hdr(64'h0000_0005_0000_0004);
    idle();
    check("t4_err_state", 64'({data_wanted, busy, done, err}), 64'b0001);
    repeat (5) @(negedge clk);
    #1;
    check("t4_err_held", 64'({data_wanted, err}), 64'b01);
    pulse_start();
    check("t4_restart", 64'({data_wanted, busy, err}), 64'b110);
    hdr(64'h8000_0000_0000_0000);
    idle();
    check("t4_recover", 64'({loaded, done}), {4'b0001, 1'b1});

    // Reset during the second payload word of a four-word segment
    pulse_start();
    hdr(64'h0000_0001_0000_0004);
    pay(1, 64'h5555_0000_0000_00D0);
    @(negedge clk);
    reset      = 1'b1;
    data       = 64'h5555_0000_0000_00D1;
    data_ready = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    data_ready = 1'b0;
    #1;
    check("t5_after_reset", 64'(outs()), 64'h000);
    pulse_start();
    hdr(64'h8000_0001_0000_0002);
    pay(1, 64'h5555_0000_0000_00E0);
    pay(1, 64'h5555_0000_0000_00E1);
    idle();
    check("t5_recovered", 64'({loaded, done}), {4'b0010, 1'b1});

    // Reload of the same client
    pulse_start();
    hdr(64'h0000_0001_0000_0002);
    pay(1, 64'h6666_0000_0000_00F0);
    pay(1, 64'h6666_0000_0000_00F1);
    @(negedge clk);
    #1;
    check("t6_first_loaded", 64'(loaded), 64'h2);
    send(64'h8000_0001_0000_0001);
    @(negedge clk);
    exp_q.push_back('{1, 64'h6666_0000_0000_00F2});
    data = 64'h6666_0000_0000_00F2;
    #1;
    check("t6_reload_dropped", 64'(loaded), 64'h0);
    send(64'h6666_0000_0000_00F2);
    idle();
    check("t6_reloaded", 64'({loaded, done}), {4'b0010, 1'b1});

    @(negedge clk);
    #4;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
